// File: rtl/note_detector.sv
// Purpose: recovers the sounding piano key from a 4-bit tone sample stream by measuring the waveform period.
// Latency: keys updates on the clk edge after the CONFIRM-th matching period's crossing is registered (crossing ~5 clk after the input edge).
// Backpressure: none; a free-running observer that never stalls its source.
//
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   sample      : 4-bit tone sample, asynchronous to clk
//   keys        : one-hot key (SOL=0001, MI=0010, RE=0100, DO=1000, none=0000)
//   note_valid  : keys is non-zero
//   period      : last measured period in clk cycles; period_stb pulses when it updates
//   timeout     : one-cycle pulse when no crossing is seen for TIMEOUT cycles
module note_detector #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int DO_HZ   = 523,
    parameter int RE_HZ   = 587,
    parameter int MI_HZ   = 659,
    parameter int SOL_HZ  = 784,
    parameter int CONFIRM = 2,
    parameter int CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       sample,
    output logic [3:0]       keys,
    output logic             note_valid,
    output logic [CNT_W-1:0] period,
    output logic             period_stb,
    output logic             timeout
);

    localparam int P_DO  = CLK_HZ / DO_HZ;
    localparam int P_RE  = CLK_HZ / RE_HZ;
    localparam int P_MI  = CLK_HZ / MI_HZ;
    localparam int P_SOL = CLK_HZ / SOL_HZ;

    // Window edges sit halfway between neighbouring nominal periods; the
    // outer edges extend by half the adjacent spacing.
    localparam logic [CNT_W-1:0] LO      = CNT_W'(P_SOL - (P_MI - P_SOL) / 2);
    localparam logic [CNT_W-1:0] M_SM    = CNT_W'((P_MI + P_SOL) / 2);
    localparam logic [CNT_W-1:0] M_MR    = CNT_W'((P_RE + P_MI) / 2);
    localparam logic [CNT_W-1:0] M_RD    = CNT_W'((P_DO + P_RE) / 2);
    localparam logic [CNT_W-1:0] HI      = CNT_W'(P_DO + (P_DO - P_RE) / 2);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(P_DO + (P_DO - P_RE) / 2 + 1);
    localparam logic [2:0]       CONF    = 3'(CONFIRM);

    typedef enum logic {
        ARM,
        MEASURE
    } state_t;

    logic [3:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [3:0]       sample_q, sample_d;
    logic             msb_q, msb_d;
    logic             xing_q, xing_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [2:0]       match_q, match_d;
    logic [3:0]       keys_q, keys_d;
    logic             note_valid_q, note_valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_stb_q, period_stb_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       cls;

    function automatic logic [3:0] classify(input logic [CNT_W-1:0] c);
        if (c >= LO && c < M_SM)        return 4'b0001;
        else if (c >= M_SM && c < M_MR) return 4'b0010;
        else if (c >= M_MR && c < M_RD) return 4'b0100;
        else if (c >= M_RD && c <= HI)  return 4'b1000;
        else                            return 4'b0000;
    endfunction

    // Capture path: two sync flops, then a stability filter so a value must
    // be seen on two consecutive cycles before it is accepted. This rejects
    // single-cycle glitches and multi-bit skew from the async source.
    always_comb begin
        s1_d     = sample;
        s2_d     = s1_q;
        s3_d     = s2_q;
        sample_d = (s2_q == s3_q) ? s2_q : sample_q;
        msb_d    = sample_q[3];
        xing_d   = sample_q[3] & ~msb_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        match_d      = match_q;
        keys_d       = keys_q;
        note_valid_d = note_valid_q;
        period_d     = period_q;
        period_stb_d = 1'b0;
        timeout_d    = 1'b0;
        cls          = classify(cnt_q);

        case (state_q)
            ARM: begin
                cnt_d = '0;
                if (xing_q) begin
                    state_d = MEASURE;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            MEASURE: begin
                // A crossing wins over an expiring counter, so a period of
                // exactly TIMEOUT is reported (as class none) rather than lost.
                if (xing_q) begin
                    period_d     = cnt_q;
                    period_stb_d = 1'b1;
                    cnt_d        = {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cls == cand_q) begin
                        match_d = (match_q >= CONF) ? CONF : match_q + 3'd1;
                    end else begin
                        cand_d  = cls;
                        match_d = 3'd1;
                    end
                    // Keys only move once the candidate has repeated enough.
                    if (match_d == CONF) begin
                        keys_d       = cand_d;
                        note_valid_d = (cand_d != 4'b0000);
                    end
                end else if (cnt_q == TIMEOUT) begin
                    keys_d       = 4'b0000;
                    note_valid_d = 1'b0;
                    timeout_d    = 1'b1;
                    cand_d       = 4'b0000;
                    match_d      = 3'd0;
                    cnt_d        = '0;
                    state_d      = ARM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 4'h0;
            s2_q         <= 4'h0;
            s3_q         <= 4'h0;
            sample_q     <= 4'h0;
            msb_q        <= 1'b0;
            xing_q       <= 1'b0;
            state_q      <= ARM;
            cnt_q        <= '0;
            cand_q       <= 4'h0;
            match_q      <= 3'd0;
            keys_q       <= 4'h0;
            note_valid_q <= 1'b0;
            period_q     <= '0;
            period_stb_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            sample_q     <= sample_d;
            msb_q        <= msb_d;
            xing_q       <= xing_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            keys_q       <= keys_d;
            note_valid_q <= note_valid_d;
            period_q     <= period_d;
            period_stb_q <= period_stb_d;
            timeout_q    <= timeout_d;
        end
    end

    assign keys       = keys_q;
    assign note_valid = note_valid_q;
    assign period     = period_q;
    assign period_stb = period_stb_q;
    assign timeout    = timeout_q;

endmodule
